// File: rtl/fir_pkg.sv
// Shared constants, FSM encoding and tap-group decode for the FIR coefficient sequencer.
package fir_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned NUM_TAPS   = 10;
  localparam int unsigned SAMPLE_DIV = 40;
  localparam int unsigned CNT_W      = $clog2(SAMPLE_DIV);

  // Last tap of each multiplier group; taps beyond GRP2_LAST fall into group 3.
  localparam logic [3:0] GRP0_LAST = 4'd3;
  localparam logic [3:0] GRP1_LAST = 4'd6;
  localparam logic [3:0] GRP2_LAST = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } fir_state_t;

  function automatic logic [3:0] tapGroup(input logic [3:0] tap);
    if (tap == 4'd0)           return 4'b0000;
    else if (tap <= GRP0_LAST) return 4'b0001;
    else if (tap <= GRP1_LAST) return 4'b0010;
    else if (tap <= GRP2_LAST) return 4'b0100;
    else                       return 4'b1000;
  endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow/active coefficient register pair; host writes land in shadow, commit copies to active.
module fir_coeff_bank
  import fir_pkg::*;
(
  input  logic              iClk_12M,
  input  logic              iRsn,
  input  logic              iWrEn,
  input  logic [3:0]        iWrAddr,
  input  logic [DATA_W-1:0] iWrData,
  input  logic              iCommit,
  input  logic [3:0]        iRdTap,
  output logic [DATA_W-1:0] oRdData,
  output logic              oPending
);

  logic [DATA_W-1:0] shadow [NUM_TAPS];
  logic [DATA_W-1:0] active [NUM_TAPS];
  logic              wrValid;
  logic              doCommit;

  assign wrValid  = iWrEn && (iWrAddr != 4'd0) && (iWrAddr <= 4'(NUM_TAPS));
  assign doCommit = iCommit && oPending;

  // A write coinciding with a commit: active takes the old shadow, pending stays set.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      oPending <= 1'b0;
    end else begin
      if (doCommit) begin
        for (int unsigned i = 0; i < NUM_TAPS; i++) active[i] <= shadow[i];
      end
      if (wrValid) begin
        for (int unsigned i = 0; i < NUM_TAPS; i++) begin
          if (iWrAddr == 4'(i + 1)) shadow[i] <= iWrData;
        end
      end
      if (wrValid)       oPending <= 1'b1;
      else if (doCommit) oPending <= 1'b0;
    end
  end

  always_comb begin
    oRdData = '0;
    for (int unsigned i = 0; i < NUM_TAPS; i++) begin
      if (iRdTap == 4'(i + 1)) oRdData = active[i];
    end
  end

endmodule

// File: rtl/fir_coeff_sequencer.sv
// Sample strobe generator, sample latch and per-tap coefficient sweep feeding the FIR MAC.
module fir_coeff_sequencer
  import fir_pkg::*;
(
  input  logic              iClk_12M,
  input  logic              iRsn,
  input  logic              iEnable,
  input  logic [DATA_W-1:0] iAdcData,
  input  logic              iCoeffWrEn,
  input  logic [3:0]        iCoeffAddr,
  input  logic [DATA_W-1:0] iCoeffData,
  output logic              oEnSample_300k,
  output logic [DATA_W-1:0] oFirIn,
  output logic [DATA_W-1:0] oCoeff,
  output logic [3:0]        oTapIdx,
  output logic [3:0]        oEnMul,
  output logic              oEnAcc,
  output logic              oEnAdd,
  output logic              oCoeffPending
);

  logic [CNT_W-1:0]  sampleCnt;
  logic              strobeTick;
  fir_state_t        state, stateNxt;
  logic [3:0]        tap, tapNxt;
  logic [DATA_W-1:0] bankRd, coeffNxt;
  logic [3:0]        tapIdxNxt, enMulNxt;
  logic              enAccNxt, enAddNxt;

  assign strobeTick = iEnable && (sampleCnt == CNT_W'(SAMPLE_DIV - 1));

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      sampleCnt      <= '0;
      oEnSample_300k <= 1'b0;
      oFirIn         <= '0;
    end else begin
      if (!iEnable || strobeTick) sampleCnt <= '0;
      else                        sampleCnt <= sampleCnt + 1'b1;
      oEnSample_300k <= strobeTick;
      if (strobeTick) oFirIn <= iAdcData;
    end
  end

  fir_coeff_bank u_bank (
    .iClk_12M (iClk_12M),
    .iRsn     (iRsn),
    .iWrEn    (iCoeffWrEn),
    .iWrAddr  (iCoeffAddr),
    .iWrData  (iCoeffData),
    .iCommit  (strobeTick),
    .iRdTap   (tap),
    .oRdData  (bankRd),
    .oPending (oCoeffPending)
  );

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      state <= IDLE;
      tap   <= '0;
    end else begin
      state <= stateNxt;
      tap   <= tapNxt;
    end
  end

  // Outputs are registered from the current state, so tap k appears k cycles after the strobe.
  always_comb begin
    stateNxt  = state;
    tapNxt    = tap;
    coeffNxt  = '0;
    tapIdxNxt = '0;
    enMulNxt  = '0;
    enAccNxt  = 1'b0;
    enAddNxt  = 1'b0;
    case (state)
      SWEEP: begin
        coeffNxt  = bankRd;
        tapIdxNxt = tap;
        enMulNxt  = tapGroup(tap);
        enAccNxt  = 1'b1;
        if (tap == 4'(NUM_TAPS)) begin
          stateNxt = DONE;
          tapNxt   = '0;
        end else begin
          tapNxt = tap + 4'd1;
        end
      end
      DONE: begin
        enAddNxt = 1'b1;
        stateNxt = IDLE;
      end
      default: ;
    endcase
    if (strobeTick) begin
      stateNxt = SWEEP;
      tapNxt   = 4'd1;
    end
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      oCoeff  <= '0;
      oTapIdx <= '0;
      oEnMul  <= '0;
      oEnAcc  <= 1'b0;
      oEnAdd  <= 1'b0;
    end else begin
      oCoeff  <= coeffNxt;
      oTapIdx <= tapIdxNxt;
      oEnMul  <= enMulNxt;
      oEnAcc  <= enAccNxt;
      oEnAdd  <= enAddNxt;
    end
  end

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Directed bench for fir_coeff_sequencer: strobe timing, sweep contents, commit rules and reset.
`timescale 1ns/1ps
module tb_fir_coeff_sequencer;
  import fir_pkg::*;

  logic              iClk_12M = 1'b0;
  logic              iRsn = 1'b0;
  logic              iEnable = 1'b0;
  logic [DATA_W-1:0] iAdcData = '0;
  logic              iCoeffWrEn = 1'b0;
  logic [3:0]        iCoeffAddr = '0;
  logic [DATA_W-1:0] iCoeffData = '0;
  logic              oEnSample_300k;
  logic [DATA_W-1:0] oFirIn;
  logic [DATA_W-1:0] oCoeff;
  logic [3:0]        oTapIdx;
  logic [3:0]        oEnMul;
  logic              oEnAcc;
  logic              oEnAdd;
  logic              oCoeffPending;

  always #5 iClk_12M = ~iClk_12M;

  fir_coeff_sequencer dut (
    .iClk_12M       (iClk_12M),
    .iRsn           (iRsn),
    .iEnable        (iEnable),
    .iAdcData       (iAdcData),
    .iCoeffWrEn     (iCoeffWrEn),
    .iCoeffAddr     (iCoeffAddr),
    .iCoeffData     (iCoeffData),
    .oEnSample_300k (oEnSample_300k),
    .oFirIn         (oFirIn),
    .oCoeff         (oCoeff),
    .oTapIdx        (oTapIdx),
    .oEnMul         (oEnMul),
    .oEnAcc         (oEnAcc),
    .oEnAdd         (oEnAdd),
    .oCoeffPending  (oCoeffPending)
  );

  typedef struct {
    logic [3:0] tap;
    logic [3:0] enMul;
  } sweepVec_t;

  sweepVec_t         tbl [NUM_TAPS];
  logic [DATA_W-1:0] mShadow [1:NUM_TAPS];
  logic [DATA_W-1:0] mActive [1:NUM_TAPS];
  logic              mPending;
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  int                refCyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge iClk_12M);
    cyc++;
  endtask

  task automatic checkAllZero(input string nm);
    chk({nm, "_strobe"},  32'(oEnSample_300k), 0);
    chk({nm, "_firin"},   32'(oFirIn), 0);
    chk({nm, "_coeff"},   32'(oCoeff), 0);
    chk({nm, "_tapidx"},  32'(oTapIdx), 0);
    chk({nm, "_enmul"},   32'(oEnMul), 0);
    chk({nm, "_enacc"},   32'(oEnAcc), 0);
    chk({nm, "_enadd"},   32'(oEnAdd), 0);
    chk({nm, "_pending"}, 32'(oCoeffPending), 0);
  endtask

  task automatic modelClear();
    for (int k = 1; k <= NUM_TAPS; k++) begin
      mShadow[k] = '0;
      mActive[k] = '0;
    end
    mPending = 1'b0;
  endtask

  task automatic modelCommit();
    if (mPending) begin
      for (int k = 1; k <= NUM_TAPS; k++) mActive[k] = mShadow[k];
      mPending = 1'b0;
    end
  endtask

  task automatic modelWrite(input logic [3:0] a, input logic [DATA_W-1:0] d);
    if (a >= 4'd1 && a <= 4'(NUM_TAPS)) begin
      mShadow[int'(a)] = d;
      mPending = 1'b1;
    end
  endtask

  task automatic hostWrite(input logic [3:0] a, input logic [DATA_W-1:0] d);
    iCoeffWrEn = 1'b1;
    iCoeffAddr = a;
    iCoeffData = d;
    tick();
    iCoeffWrEn = 1'b0;
    modelWrite(a, d);
  endtask

  task automatic waitStrobe(input logic [DATA_W-1:0] sample);
    bit seen;
    seen = 1'b0;
    iAdcData = sample;
    for (int n = 0; n < 60 && !seen; n++) begin
      tick();
      if (oEnSample_300k) seen = 1'b1;
    end
    chk("strobe_seen", 32'(seen), 1);
    chk("strobe_gap", 32'(cyc - refCyc), SAMPLE_DIV);
    refCyc = cyc;
    modelCommit();
    chk("fir_in", 32'(oFirIn), 32'(sample));
    chk("pending_at_strobe", 32'(oCoeffPending), 32'(mPending));
  endtask

  // Starts on the strobe cycle; optionally injects a host write or asserts reset at a given tap.
  task automatic checkSweep(input int injAt, input logic [3:0] injAddr,
                            input logic [DATA_W-1:0] injData, input int rstAt);
    for (int k = 1; k <= NUM_TAPS; k++) begin
      tick();
      if (iCoeffWrEn) begin
        iCoeffWrEn = 1'b0;
        modelWrite(injAddr, injData);
      end
      chk("tap_idx", 32'(oTapIdx), 32'(tbl[k-1].tap));
      chk("coeff",   32'(oCoeff),  32'(mActive[k]));
      chk("en_mul",  32'(oEnMul),  32'(tbl[k-1].enMul));
      chk("en_acc",  32'(oEnAcc),  1);
      chk("en_add",  32'(oEnAdd),  0);
      if (k == rstAt) begin
        iRsn = 1'b0;
        #1;
        checkAllZero("rst_async");
        modelClear();
        return;
      end
      if (k == injAt) begin
        iCoeffWrEn = 1'b1;
        iCoeffAddr = injAddr;
        iCoeffData = injData;
      end
    end
    tick();
    chk("done_en_add", 32'(oEnAdd), 1);
    chk("done_en_acc", 32'(oEnAcc), 0);
    chk("done_tap_idx", 32'(oTapIdx), 0);
    chk("done_coeff", 32'(oCoeff), 0);
    chk("done_en_mul", 32'(oEnMul), 0);
    tick();
    chk("idle_en_add", 32'(oEnAdd), 0);
  endtask

  initial begin
    tbl = '{'{4'd1, 4'b0001}, '{4'd2, 4'b0001}, '{4'd3, 4'b0001},
            '{4'd4, 4'b0010}, '{4'd5, 4'b0010}, '{4'd6, 4'b0010},
            '{4'd7, 4'b0100}, '{4'd8, 4'b0100}, '{4'd9, 4'b0100},
            '{4'd10, 4'b1000}};
    modelClear();

    repeat (3) tick();
    checkAllZero("reset");
    iRsn = 1'b1;
    iEnable = 1'b1;
    refCyc = cyc;

    waitStrobe(16'h1111);
    checkSweep(0, 4'd0, '0, 0);

    for (int k = 1; k <= NUM_TAPS; k++) hostWrite(4'(k), 16'(k * 256));
    chk("pending_after_writes", 32'(oCoeffPending), 1);

    // Tap 5 rewritten mid-sweep must not show until the following sweep.
    waitStrobe(16'h2222);
    checkSweep(2, 4'd5, 16'h7FFF, 0);
    chk("pending_after_midsweep_write", 32'(oCoeffPending), 1);
    waitStrobe(16'h3333);
    checkSweep(0, 4'd0, '0, 0);

    // Write on the exact strobe edge while a commit is also due.
    hostWrite(4'd7, 16'h1234);
    while (cyc < refCyc + SAMPLE_DIV - 1) tick();
    iAdcData = 16'h4444;
    iCoeffWrEn = 1'b1;
    iCoeffAddr = 4'd3;
    iCoeffData = 16'h8000;
    tick();
    iCoeffWrEn = 1'b0;
    chk("edge_strobe", 32'(oEnSample_300k), 1);
    chk("edge_gap", 32'(cyc - refCyc), SAMPLE_DIV);
    refCyc = cyc;
    modelCommit();
    modelWrite(4'd3, 16'h8000);
    chk("edge_pending", 32'(oCoeffPending), 1);
    chk("edge_fir_in", 32'(oFirIn), 32'h4444);
    checkSweep(0, 4'd0, '0, 0);
    waitStrobe(16'h5555);
    checkSweep(0, 4'd0, '0, 0);

    hostWrite(4'd0, 16'hDEAD);
    hostWrite(4'd11, 16'hBEEF);
    chk("pending_bad_addr", 32'(oCoeffPending), 0);

    waitStrobe(16'h6666);
    checkSweep(0, 4'd0, '0, 6);
    repeat (2) tick();
    checkAllZero("rst_hold");
    iRsn = 1'b1;
    refCyc = cyc;
    waitStrobe(16'h7777);
    checkSweep(0, 4'd0, '0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_coeff_sequencer.md
Name: fir_coeff_sequencer

Overview:
Upstream control stage for the transposed-form FIR MAC datapath.
- Derives the 300 kHz sample strobe from the 12 MHz clock.
- Latches each new input sample.
- Double-buffers a 10-tap coefficient bank written by the host; shadow-to-active updates happen only on sample boundaries.
- After each strobe, presents one coefficient per clock with matching control enables, so the MAC stage sees a consistent sample/coefficient set.

Parameters:
- SAMPLE_DIV, 40, clock cycles per sample period (12 MHz / 300 kHz); must be >= NUM_TAPS+2.
- NUM_TAPS, 10, number of filter taps; taps are indexed 1..NUM_TAPS.
- DATA_W, 16, sample and coefficient width (signed).

Ports:
- iClk_12M  in  1  system clock, 12 MHz.
- iRsn  in  1  asynchronous reset, active-low; all state clears immediately on assertion.
- iEnable  in  1  run enable; when low, the sample counter holds at 0 and no new strobes are generated.
- iAdcData  in  DATA_W  signed input sample, sampled on the strobe edge.
- iCoeffWrEn  in  1  host coefficient write strobe.
- iCoeffAddr  in  4  tap index to write (valid range 1..NUM_TAPS).
- iCoeffData  in  DATA_W  signed coefficient write data.
- oEnSample_300k  out  1  one-cycle sample strobe.
- oFirIn  out  DATA_W  latched sample, held for the whole sample period.
- oCoeff  out  DATA_W  active coefficient for the current tap.
- oTapIdx  out  4  current tap index (1..NUM_TAPS); 0 when idle.
- oEnMul  out  4  one-hot tap-group enable: bit g is set while tap is in group g (taps 1-3, 4-6, 7-9, 10).
- oEnAcc  out  1  high on every SWEEP cycle.
- oEnAdd  out  1  one-cycle pulse after the final tap.
- oCoeffPending  out  1  set when the shadow bank differs from the active bank, i.e. a write is awaiting commit.

Behaviour:
- Reset: all outputs, the counter, FSM state, shadow bank and active bank go to 0; FSM enters IDLE.
- Sample counter:
  - Counts 0..SAMPLE_DIV-1 and wraps while iEnable=1.
  - On the edge where the count is SAMPLE_DIV-1, oEnSample_300k is registered high for exactly one cycle.
  - Result: with iEnable held high, strobes occur every SAMPLE_DIV cycles; the first strobe is SAMPLE_DIV cycles after reset release.
  - If iEnable goes low, the counter resets to 0 on the next edge.
- On the strobe edge (the same edge that raises oEnSample_300k):
  - oFirIn <= iAdcData.
  - If oCoeffPending=1: active <= shadow (the pre-write shadow contents) and pending clears.
  - FSM moves to SWEEP with tap=1.
- FSM states: IDLE -> SWEEP -> DONE -> IDLE.
  - SWEEP: lasts NUM_TAPS cycles. Each cycle drives oCoeff=active[tap], oTapIdx=tap, oEnAcc=1, and the oEnMul group bit. tap increments each cycle. After tap=NUM_TAPS, go to DONE.
  - DONE: one cycle, oEnAdd=1, then IDLE.
  - IDLE: oEnAcc=0, oEnAdd=0, oEnMul=0, oTapIdx=0, oCoeff=0.
  - Latency: strobe high on cycle T; tap k is presented on cycle T+k; oEnAdd is high on cycle T+NUM_TAPS+1.
- Strobe while the FSM is not IDLE cannot occur because SAMPLE_DIV >= NUM_TAPS+2. Should it occur anyway, the FSM restarts SWEEP at tap 1.
- iEnable deasserted mid-sweep: the sweep and DONE complete normally; no further strobes.
- Coefficient writes:
  - iCoeffWrEn with addr in 1..NUM_TAPS: shadow[addr] <= iCoeffData and pending <= 1, on the next edge.
  - Addr 0 or addr > NUM_TAPS: write ignored; pending is unchanged.
  - Write on the same edge as a commit: the commit uses the old shadow, the write lands in shadow, and pending stays 1, so it commits at the next strobe.
  - Writes during SWEEP never alter oCoeff within that sweep.
- Reset asserted mid-sweep: outputs clear asynchronously; after release, behaviour restarts from the counter at 0.

Decomposition:
- Shared package fir_pkg holds:
  - DATA_W, NUM_TAPS, SAMPLE_DIV.
  - FSM state encoding (IDLE=2'd0, SWEEP=2'd1, DONE=2'd2).
  - Tap-group boundary constants.
- Natural sub-module: fir_coeff_bank, the shadow/active register pair with commit and pending logic.
- The top level holds the counter, FSM, and sample latch.

Test Plan:
- Reset release, iEnable=1, no writes -> first oEnSample_300k at cycle 40, then every 40 cycles; oCoeff=0 for taps 1..10; oEnAdd at strobe+11.
- Write taps 1..10 with values 0x0100*k, then wait for a strobe -> sweep outputs 0x0100..0x0A00 in tap order; oCoeffPending falls on the strobe edge; oEnMul sequence 0001x3, 0010x3, 0100x3, 1000x1.
- Write tap 5 = 0x7FFF mid-sweep -> current sweep still shows the old tap 5; next sweep shows 0x7FFF.
- Write tap 3 = 0x8000 on the exact strobe edge -> that sweep shows the old tap 3; pending stays 1; the following sweep shows 0x8000.
- Write addr 0 and addr 11 -> no shadow change; oCoeffPending stays 0.
- iRsn pulsed low at tap 6 -> all outputs 0 immediately; the next strobe comes 40 cycles after release; the active bank is zeroed.
